// File: rtl/seq_detector_pkg.sv
// Shared types and default constants for the programmable serial sequence detector.
package seq_detector_pkg;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } ovl_mode_e;

    localparam int          SEQ_DEF_PAT_W   = 8;
    localparam logic [31:0] SEQ_DEF_RST_PAT = 32'b1011;
    localparam int          SEQ_DEF_RST_LEN = 4;

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Runtime-programmable serial sequence detector with registered match flag.
// Macro SEQ_DETECTOR_COUNT_EN builds the saturating match counter; otherwise match_cnt is 0.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = SEQ_DEF_PAT_W,
    parameter int               LEN_W   = $clog2(PAT_W + 1),
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(SEQ_DEF_RST_PAT),
    parameter int               RST_LEN = SEQ_DEF_RST_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, PAT_W));

    logic [PAT_W-1:0] hist, hist_n, hist_d;
    logic [PAT_W-1:0] pat, pat_d;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] len, len_d;
    logic [LEN_W-1:0] fill, fill_n, fill_d;
    ovl_mode_e        ovl, ovl_d;
    logic             z_d;
    logic             sample;
    logic             hit;

    assign sample = x_valid & ~cfg_load;

    always_comb begin
        hist_n = {hist[PAT_W-2:0], x};
        fill_n = (fill < len) ? LEN_W'(fill + 1'b1) : len;
        mask   = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = sample && (len != '0) && (fill_n == len)
              && (((hist_n ^ pat) & mask) == '0);
    end

    // cfg_load discards any same-cycle sample and restarts collection
    always_comb begin
        hist_d = hist;
        fill_d = fill;
        pat_d  = pat;
        len_d  = len;
        ovl_d  = ovl;
        z_d    = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pat;
            len_d  = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
            ovl_d  = ovl_mode_e'(cfg_ovl);
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = hist_n;
            z_d    = hit;
            if (hit) begin
                fill_d = (ovl == OVERLAP) ? len : '0;
            end else begin
                fill_d = fill_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
            pat  <= RST_PAT;
            len  <= RST_LEN_C;
            ovl  <= OVERLAP;
            z    <= 1'b0;
        end else begin
            hist <= hist_d;
            fill <= fill_d;
            pat  <= pat_d;
            len  <= len_d;
            ovl  <= ovl_d;
            z    <= z_d;
        end
    end

    // The oldest history bit only ever shifts out.
    logic unused_hist_msb;
    assign unused_hist_msb = hist[PAT_W-1];

`ifdef SEQ_DETECTOR_COUNT_EN
    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .q     (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed table-driven bench for seq_detector (default and 2-bit-counter instances).
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x, x_valid, cfg_load, cfg_ovl, cnt_clr;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       z, z2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_detector u_dut (
        .clk (clk), .rst_n (rst_n), .x (x), .x_valid (x_valid),
        .cfg_load (cfg_load), .cfg_pat (cfg_pat), .cfg_len (cfg_len),
        .cfg_ovl (cfg_ovl), .cnt_clr (cnt_clr),
        .z (z), .match_cnt (match_cnt)
    );

    seq_detector #(.CNT_W(2)) u_sat (
        .clk (clk), .rst_n (rst_n), .x (x), .x_valid (x_valid),
        .cfg_load (cfg_load), .cfg_pat (cfg_pat), .cfg_len (cfg_len),
        .cfg_ovl (cfg_ovl), .cnt_clr (cnt_clr),
        .z (z2), .match_cnt (match_cnt2)
    );

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       valid;
        logic       xb;
        logic       ez;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic int cexp(input int n);
`ifdef SEQ_DETECTOR_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic int sexp(input int n);
        return cexp(n > 3 ? 3 : n);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ez, input int ecnt);
        chk({tag, " z"}, int'(z), int'(ez));
        chk({tag, " cnt"}, int'(match_cnt), cexp(ecnt));
        chk({tag, " z2"}, int'(z2), int'(ez));
        chk({tag, " cnt2"}, int'(match_cnt2), sexp(ecnt));
    endtask

    task automatic drive(input logic c, input logic ld, input logic [7:0] p,
                         input logic [3:0] l, input logic o, input logic v, input logic xb);
        cnt_clr  = c;
        cfg_load = ld;
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        x_valid  = v;
        x        = xb;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic ld, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic v, input logic xb, input logic ez, input int ecnt);
        vec_t r;
        r.clr = c; r.load = ld; r.pat = p; r.len = l; r.ovl = o;
        r.valid = v; r.xb = xb; r.ez = ez; r.ecnt = ecnt;
        vecs.push_back(r);
    endtask

    task automatic bitv(input logic xb, input logic ez, input int ecnt);
        add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb, ez, ecnt);
    endtask

    task automatic gap(input int ecnt);
        add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ecnt);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic c, input int ecnt);
        add(c, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0, ecnt);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_all("reset", 1'b0, 0);

        // default 1011 overlapping
        bitv(1,0,0); bitv(0,0,0); bitv(1,0,0); bitv(1,1,1);
        bitv(0,0,1); bitv(1,0,1); bitv(1,1,2);
        // 110 non-overlap
        load(8'b0000_0110, 4'd3, 1'b0, 1'b0, 2);
        bitv(1,0,2); bitv(1,0,2); bitv(0,1,3); bitv(1,0,3); bitv(1,0,3); bitv(0,1,4);
        // 110 overlap
        load(8'b0000_0110, 4'd3, 1'b1, 1'b0, 4);
        bitv(1,0,4); bitv(1,0,4); bitv(0,1,5); bitv(1,0,5); bitv(1,0,5); bitv(0,1,6);
        // 1101110 overlap then non-overlap
        load(8'b0000_0110, 4'd3, 1'b1, 1'b0, 6);
        bitv(1,0,6); bitv(1,0,6); bitv(0,1,7); bitv(1,0,7); bitv(1,0,7); bitv(1,0,7); bitv(0,1,8);
        load(8'b0000_0110, 4'd3, 1'b0, 1'b0, 8);
        bitv(1,0,8); bitv(1,0,8); bitv(0,1,9); bitv(1,0,9); bitv(1,0,9); bitv(1,0,9); bitv(0,1,10);
        // 11 non-overlap vs overlap
        load(8'b0000_0011, 4'd2, 1'b0, 1'b0, 10);
        bitv(1,0,10); bitv(1,1,11); bitv(1,0,11); bitv(1,1,12);
        load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 12);
        bitv(1,0,12); bitv(1,1,13); bitv(1,1,14); bitv(1,1,15);
        // load together with clear, then 1011 with a 3-cycle valid gap
        load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 0);
        bitv(1,0,0); bitv(0,0,0); gap(0); gap(0); gap(0); bitv(1,0,0); bitv(1,1,1); gap(1);
        // load on the completing bit discards it
        bitv(1,0,1); bitv(0,0,1); bitv(1,0,1);
        add(1'b0, 1'b1, 8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        bitv(1,0,1); bitv(0,0,1); bitv(1,0,1); bitv(1,1,2);
        // zero length disables detection
        load(8'b0000_0000, 4'd0, 1'b1, 1'b0, 2);
        bitv(1,0,2); bitv(0,0,2); bitv(1,0,2); bitv(1,0,2); bitv(0,0,2); bitv(0,0,2);
        // oversize length clamps to 8
        load(8'hA5, 4'd15, 1'b1, 1'b0, 2);
        bitv(1,0,2); bitv(0,0,2); bitv(1,0,2); bitv(0,0,2);
        bitv(0,0,2); bitv(1,0,2); bitv(0,0,2); bitv(1,1,3);
        // clear concurrent with a match
        load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 3);
        bitv(1,0,3);
        add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        bitv(1,1,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].pat, vecs[i].len,
                  vecs[i].ovl, vecs[i].valid, vecs[i].xb);
            check_all($sformatf("row%0d", i), vecs[i].ez, vecs[i].ecnt);
        end

        // asynchronous reset clears z and count without a clock edge
        rst_n = 1'b0;
        #2;
        check_all("async_rst", 1'b0, 0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // partial 101 lost on reset pulse
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); check_all("pre1", 1'b0, 0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0); check_all("pre0", 1'b0, 0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); check_all("pre1b", 1'b0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); check_all("post_rst_1", 1'b0, 0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0); check_all("post_rst_0", 1'b0, 0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); check_all("post_rst_1b", 1'b0, 0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1); check_all("post_rst_hit", 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
